// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier with valid/ready handshakes.
// Each operand pair takes WIDTH cycles in CALC, and the product is held in DONE until the consumer takes it.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   sum_s;

  // The multiplicand shifts left and the multiplier shifts right, so bit 0 always selects the current partial product.
  assign sum_s = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = {PW{1'b0}};
          cnt_d    = CW'(WIDTH - 1);
          state_d  = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d    = sum_s;
        mcand_d  = mcand_q << 1'b1;
        mplier_d = mplier_q >> 1'b1;
        if (cnt_q == {CW{1'b0}}) begin
          result_d = sum_s;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= {PW{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {PW{1'b0}};
      result_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign result    = result_q;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential unsigned shift-and-add multiplier with valid/ready handshakes on its operand and result sides. It is the responding end of the multiplier stimulus/check flow: it accepts an operand pair, computes the 2*WIDTH-bit product over WIDTH cycles and presents it until the consumer takes it. It replaces a single-cycle combinational multiplier wherever area matters more than latency.

## Interface

- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..32.

- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion, released synchronously by the system.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  result holds a new product; high only in DONE.
- out_ready  input  1  consumer accepts result.
- result  output  2*WIDTH  last completed product, registered.
- busy  output  1  high in CALC or DONE.

## Operation

- States: IDLE, CALC, DONE; reset state IDLE.
- IDLE: in_ready=1. On an edge with in_valid=1, capture a and b, clear the accumulator, load bit counter = WIDTH-1, go to CALC.
- CALC: one multiplier bit per cycle, LSB first. If the current bit is 1, add the multiplicand, shifted to that bit position, into the 2*WIDTH-bit accumulator. Decrement the counter. On the edge where the counter is 0, write the accumulator to result and go to DONE.
- DONE: out_valid=1. On an edge with out_ready=1, go to IDLE. Otherwise hold, with result and out_valid stable.
- Arithmetic: result = a*b exactly, unsigned; 2*WIDTH bits never overflow; no signed mode.
- Capture and latching:
  - a and b are sampled only on the capture edge; later changes have no effect.
  - in_valid outside IDLE is ignored; operands offered then are not queued.
  - result is written only on the CALC→DONE edge and persists through IDLE until the next completion.
- Reset, at any time including mid-CALC or in DONE:
  - state=IDLE, result=0, out_valid=0, busy=0, accumulator and counter cleared.
  - The in-flight operation is discarded.
  - in_ready=1 once reset is deasserted.

## Timing

- Reset values: in_ready=1, out_valid=0, busy=0, result=0.
- Capture edge E0 (IDLE, in_valid=1): in_ready falls and busy rises after E0.
- Latency: DONE is entered on edge E0+WIDTH; out_valid and the final result are visible after E0+WIDTH. With WIDTH=8 this is 8 cycles.
- Result consumption and next capture:
  - Result is taken on the first edge in DONE with out_ready=1. out_valid falls and in_ready rises after that edge.
  - The earliest next capture is the following edge.
- Minimum operation period: WIDTH+2 cycles (10 for WIDTH=8). An out_ready held high is not a fast path.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Simultaneous events:
  - in_valid in DONE together with out_ready: the result is taken and the operands are ignored.
  - reset overrides every other event.

## Test plan

- Reset then a=5, b=3, in_valid for one cycle in IDLE: in_ready falls after the capture edge, out_valid rises exactly 8 edges later with result=15, and busy=1 throughout.
- Corner operands, one at a time: 255*255 gives result=65025, 0*100 gives 0, 128*128 gives 16384, 127*129 gives 16383, 1*255 gives 255; each has out_valid at E0+8.
- Backpressure: complete 10*4 with out_ready=0 for 5 cycles, and drive in_valid with a=2, b=2 during the stall. Required:
  - out_valid stays 1, result stays 40 and in_ready stays 0 throughout.
  - After out_ready=1 the block returns to IDLE and the 2*2 request was never captured.
- Reset mid-operation: capture 127*129, assert reset at E0+3. Required:
  - result=0, out_valid=0, busy=0 and in_ready=1 immediately.
  - After release, 15*2 completes with result=30 and no residue.
- Operand stability: capture 200*3, then change a to 0 and b to 255 during CALC; result=600.
- Back-to-back with in_valid and out_ready held high, pairs 6*7 then 9*9: results 42 then 81, with capture edges exactly 10 cycles apart.
